alksio_seq: RTL and testbench

- Shift-linkage sequencer at the far end of the ALU_SIO[31,0] lines: the counterpart of the ALK-side shift in/out routing.
- For every step of a multi-bit ALU shift, it:
  - drives the fill bit onto the entry-end ALU_SIO pad;
  - samples the bit shifted out on the exit-end pad;
  - keeps a link (carry) bit;
  - counts steps.
- Runs under a start/busy/done handshake from the microsequencer and pulses one ALU shift step per cycle.

---
 rtl/alksio_seq_if.sv | 35 +++
 rtl/alksio_seq.sv | 104 ++++++++++
 tb/tb_alksio_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alksio_seq_if.sv
// ALU_SIO shift-linkage bus: microsequencer handshake, ALU status and the
// two low-true shift pads, grouped for the alksio_seq far-end sequencer.
interface alksio_seq_if #(
  parameter int CNT_W = 5
);
  logic             start_h;
  logic             dir_right_h;
  logic [1:0]       mode_h;
  logic [CNT_W-1:0] count_h;
  logic             link_in_h;
  logic             alu_sign_h;
  logic             alu_sio0_in_l;
  logic             alu_sio31_in_l;
  logic             alu_sio0_out_l;
  logic             alu_sio31_out_l;
  logic             alu_step_h;
  logic             busy_h;
  logic             done_h;
  logic             link_h;
  logic             ovf_h;

  modport slave (
    input  start_h, dir_right_h, mode_h, count_h, link_in_h,
           alu_sign_h, alu_sio0_in_l, alu_sio31_in_l,
    output alu_sio0_out_l, alu_sio31_out_l, alu_step_h,
           busy_h, done_h, link_h, ovf_h
  );

  modport master (
    output start_h, dir_right_h, mode_h, count_h, link_in_h,
           alu_sign_h, alu_sio0_in_l, alu_sio31_in_l,
    input  alu_sio0_out_l, alu_sio31_out_l, alu_step_h,
           busy_h, done_h, link_h, ovf_h
  );
endinterface

// File: rtl/alksio_seq.sv
// Far-end shift-linkage sequencer: drives the fill bit onto the entry pad,
// captures the exit-pad bit into the link register and counts shift steps.
module alksio_seq #(
  parameter int CNT_W = 5
) (
  input  logic         clk_h,
  input  logic         reset_l,
  alksio_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_dir;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_remaining;
  logic             r_link;
  logic             r_ovf;
  logic             w_fill;
  logic             w_out_bit;
  logic             w_accept;

  assign w_accept  = (r_state == S_IDLE) && bus.start_h;
  assign w_out_bit = r_dir ? ~bus.alu_sio0_in_l : ~bus.alu_sio31_in_l;

  always_comb begin
    w_fill = 1'b0;
    unique case (r_mode)
      2'b00: w_fill = 1'b0;
      2'b01: w_fill = r_dir ? bus.alu_sign_h : 1'b0;
      2'b10: w_fill = r_link;
      2'b11: w_fill = 1'b1;
    endcase
  end

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start_h) w_next = (bus.count_h != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (r_remaining == CNT_W'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      r_dir       <= 1'b0;
      r_mode      <= 2'b00;
      r_remaining <= '0;
      r_link      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      r_link <= bus.link_in_h;
      r_ovf  <= 1'b0;
      if (bus.count_h != '0) begin
        r_dir       <= bus.dir_right_h;
        r_mode      <= bus.mode_h;
        r_remaining <= bus.count_h;
      end
    end else if (r_state == S_SHIFT) begin
      r_link      <= w_out_bit;
      r_remaining <= r_remaining - CNT_W'(1);
      // Arithmetic left overflows when a bit unlike the new sign leaves bit 31.
      if (r_mode == 2'b01 && !r_dir && (w_out_bit != bus.alu_sign_h))
        r_ovf <= 1'b1;
    end
  end

  always_comb begin
    bus.alu_sio0_out_l  = 1'b1;
    bus.alu_sio31_out_l = 1'b1;
    bus.alu_step_h      = 1'b0;
    bus.busy_h          = 1'b0;
    bus.done_h          = 1'b0;
    unique case (r_state)
      S_SHIFT: begin
        bus.busy_h     = 1'b1;
        bus.alu_step_h = 1'b1;
        if (r_dir) bus.alu_sio31_out_l = ~w_fill;
        else       bus.alu_sio0_out_l  = ~w_fill;
      end
      S_DONE: begin
        bus.busy_h = 1'b1;
        bus.done_h = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.link_h = r_link;
  assign bus.ovf_h  = r_ovf;

endmodule

// File: tb/tb_alksio_seq.sv
// Directed bench for alksio_seq: hand-computed pad, handshake and link/ovf
// values cycle by cycle for each shift mode, zero count, held start and reset.
module tb_alksio_seq;

  logic clk_h;
  logic reset_l;
  int unsigned n_checks;
  int unsigned n_pass;

  alksio_seq_if #(.CNT_W(5)) bus ();

  alksio_seq #(.CNT_W(5)) dut (
    .clk_h   (clk_h),
    .reset_l (reset_l),
    .bus     (bus)
  );

  initial begin
    clk_h = 1'b0;
    forever #5 clk_h = ~clk_h;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic busy, input logic step,
                         input logic done, input logic p0, input logic p31);
    chk({tag, ".busy"},  32'(bus.busy_h),          32'(busy));
    chk({tag, ".step"},  32'(bus.alu_step_h),      32'(step));
    chk({tag, ".done"},  32'(bus.done_h),          32'(done));
    chk({tag, ".sio0"},  32'(bus.alu_sio0_out_l),  32'(p0));
    chk({tag, ".sio31"}, 32'(bus.alu_sio31_out_l), 32'(p31));
  endtask

  task automatic cyc();
    @(posedge clk_h);
    #1;
  endtask

  task automatic start_seq(input logic dir, input logic [1:0] mode,
                           input logic [4:0] cnt, input logic lnk);
    bus.start_h     = 1'b1;
    bus.dir_right_h = dir;
    bus.mode_h      = mode;
    bus.count_h     = cnt;
    bus.link_in_h   = lnk;
    #1;
    chk_ctl("idle_pre", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc();
    bus.start_h = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_l             = 1'b0;
    bus.start_h         = 1'b0;
    bus.dir_right_h     = 1'b0;
    bus.mode_h          = 2'b00;
    bus.count_h         = '0;
    bus.link_in_h       = 1'b0;
    bus.alu_sign_h      = 1'b0;
    bus.alu_sio0_in_l   = 1'b1;
    bus.alu_sio31_in_l  = 1'b1;

    #12;
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst.link", 32'(bus.link_h), 0);
    chk("rst.ovf",  32'(bus.ovf_h),  0);
    reset_l = 1'b1;
    cyc();

    // Logical left, 3 steps, out bits 1,0,1
    start_seq(1'b0, 2'b00, 5'd3, 1'b1);
    bus.alu_sio31_in_l = 1'b0; #1;
    chk_ctl("ll1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(); chk("ll1.link", 32'(bus.link_h), 1);
    bus.alu_sio31_in_l = 1'b1; #1;
    chk_ctl("ll2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(); chk("ll2.link", 32'(bus.link_h), 0);
    bus.alu_sio31_in_l = 1'b0; #1;
    chk_ctl("ll3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc();
    chk_ctl("ll_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("ll_done.link", 32'(bus.link_h), 1);
    bus.alu_sio31_in_l = 1'b1;
    cyc();
    chk_ctl("ll_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ll_idle.link", 32'(bus.link_h), 1);

    // Through-link right, 2 steps, out bits 0,1
    start_seq(1'b1, 2'b10, 5'd2, 1'b1);
    bus.alu_sio0_in_l = 1'b1; #1;
    chk_ctl("tr1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(); chk("tr1.link", 32'(bus.link_h), 0);
    bus.alu_sio0_in_l = 1'b0; #1;
    chk_ctl("tr2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc();
    bus.alu_sio0_in_l = 1'b1;
    chk_ctl("tr_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("tr_done.link", 32'(bus.link_h), 1);
    cyc();

    // Arithmetic left, sign 0, out bits 0 then 1 -> overflow
    bus.alu_sign_h = 1'b0;
    start_seq(1'b0, 2'b01, 5'd2, 1'b0);
    bus.alu_sio31_in_l = 1'b1; #1;
    chk_ctl("al1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(); chk("al1.ovf", 32'(bus.ovf_h), 0);
    bus.alu_sio31_in_l = 1'b0; #1;
    cyc();
    bus.alu_sio31_in_l = 1'b1;
    chk("al_done.ovf", 32'(bus.ovf_h), 1);
    chk("al_done.done", 32'(bus.done_h), 1);
    cyc();
    chk("al_idle.ovf", 32'(bus.ovf_h), 1);

    // Arithmetic right, sign 1: new start clears ovf, fills with sign
    bus.alu_sign_h = 1'b1;
    start_seq(1'b1, 2'b01, 5'd1, 1'b1);
    bus.alu_sio0_in_l = 1'b1; #1;
    chk_ctl("ar1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ar1.ovf", 32'(bus.ovf_h), 0);
    cyc();
    bus.alu_sign_h = 1'b0;
    chk("ar_done.link", 32'(bus.link_h), 0);
    chk("ar_done.done", 32'(bus.done_h), 1);
    cyc();

    // Zero count: straight to DONE, link loaded, no step
    start_seq(1'b0, 2'b11, 5'd0, 1'b1);
    chk_ctl("z_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("z_done.link", 32'(bus.link_h), 1);
    cyc();
    chk_ctl("z_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // One-fill left with start held high: restart only after an IDLE cycle
    bus.start_h = 1'b1; bus.dir_right_h = 1'b0; bus.mode_h = 2'b11;
    bus.count_h = 5'd4; bus.link_in_h = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk_ctl($sformatf("h1_%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc();
    end
    chk_ctl("h1_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc();
    chk_ctl("h_gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc();
    bus.start_h = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_ctl($sformatf("h2_%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc();
    end
    chk_ctl("h2_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc();
    chk_ctl("h2_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset after two steps of a 5-step sequence
    bus.alu_sio31_in_l = 1'b0;
    start_seq(1'b0, 2'b11, 5'd5, 1'b0);
    cyc(); cyc();
    chk_ctl("rm_pre", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rm_pre.link", 32'(bus.link_h), 1);
    reset_l = 1'b0; #1;
    chk_ctl("rm_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rm_rst.link", 32'(bus.link_h), 0);
    cyc();
    reset_l = 1'b1;
    bus.alu_sio31_in_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_ctl($sformatf("rm_post%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
